aes_shift_mix: RTL and testbench

- Round-datapath stage directly downstream of the byte-substitution S-box array.
- Takes the 128-bit state after SubBytes and applies ShiftRows.
- In normal rounds it then applies MixColumns iteratively, COLS_PER_CYCLE columns per cycle. In the final round MixColumns is bypassed.
- Valid/ready handshake on both sides; the result feeds AddRoundKey.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_mix_column.sv | 24 ++
 rtl/aes_shift_mix.sv | 107 ++++++++++
 tb/tb_aes_shift_mix.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte/column helpers and constants, reused by the round datapath,
// key expansion and inverse stages.
package aes_pkg;

  localparam int        AES_STATE_W = 128;
  localparam logic [7:0] AES_RED    = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } sm_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? AES_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    gf_mul2 = xtime(x);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    gf_mul3 = xtime(x) ^ x;
  endfunction

  // Column-major byte order: byte k sits at bits [127-8k -: 8], k = 4*col + row.
  function automatic logic [7:0] byte_at(input logic [AES_STATE_W-1:0] state,
                                         input int row, input int col);
    byte_at = state[AES_STATE_W-1-8*(4*col+row) -: 8];
  endfunction

  function automatic logic [31:0] col_at(input logic [AES_STATE_W-1:0] state,
                                         input int col);
    col_at = state[AES_STATE_W-1-32*col -: 32];
  endfunction

  function automatic logic [AES_STATE_W-1:0] shift_rows(input logic [AES_STATE_W-1:0] state);
    logic [AES_STATE_W-1:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[AES_STATE_W-1-8*(4*c+r) -: 8] = byte_at(state, r, (c + r) % 4);
      end
    end
    shift_rows = res;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns on a single 32-bit column (a0 in the MSB byte).
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_b0, w_b1, w_b2, w_b3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_b0 = gf_mul2(w_a0) ^ gf_mul3(w_a1) ^ w_a2          ^ w_a3;
  assign w_b1 = w_a0          ^ gf_mul2(w_a1) ^ gf_mul3(w_a2) ^ w_a3;
  assign w_b2 = w_a0          ^ w_a1          ^ gf_mul2(w_a2) ^ gf_mul3(w_a3);
  assign w_b3 = gf_mul3(w_a0) ^ w_a1          ^ w_a2          ^ gf_mul2(w_a3);

  assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/aes_shift_mix.sv
// AES round stage after SubBytes: ShiftRows at capture, then iterative
// MixColumns (skipped in the final round), valid/ready on both sides.
module aes_shift_mix
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_final,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  localparam int MIX_CYCLES = (COLS_PER_CYCLE > 0) ? (4 / COLS_PER_CYCLE) : 1;
  localparam int LAST_I     = (MIX_CYCLES - 1) * COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = LAST_I[1:0];
  // With four columns per cycle the step truncates to 0; col_cnt then stays at 0.
  localparam logic [1:0] COL_STEP = COLS_PER_CYCLE[1:0];

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_shift_mix: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  sm_state_e              r_fsm, w_fsm_nxt;
  logic [AES_STATE_W-1:0] r_state;
  logic [1:0]             r_col_cnt;
  logic                   r_final;
  logic                   w_capture;
  logic                   w_mix_step;
  logic [AES_STATE_W-1:0] w_state_mixed;

  logic [1:0]  w_idx     [COLS_PER_CYCLE];
  logic [31:0] w_col_in  [COLS_PER_CYCLE];
  logic [31:0] w_col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign w_idx[g]    = r_col_cnt + 2'(g);
    assign w_col_in[g] = col_at(r_state, int'(w_idx[g]));

    aes_mix_column u_mix (
      .i_col (w_col_in[g]),
      .o_col (w_col_out[g])
    );
  end

  always_comb begin
    w_state_mixed = r_state;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      w_state_mixed[AES_STATE_W-1-32*int'(w_idx[g]) -: 32] = w_col_out[g];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt  = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    w_capture  = 1'b0;
    w_mix_step = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_capture = 1'b1;
          w_fsm_nxt = in_final ? ST_DONE : ST_MIX;
        end
      end
      ST_MIX: begin
        // A latched final flag never mixes; it only reaches here on a corrupt path.
        w_mix_step = !r_final;
        if (r_final || r_col_cnt == LAST_CNT) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= '0;
      r_col_cnt <= 2'd0;
      r_final   <= 1'b0;
    end else if (w_capture) begin
      r_state   <= shift_rows(in_state);
      r_col_cnt <= 2'd0;
      r_final   <= in_final;
    end else if (w_mix_step) begin
      r_state   <= w_state_mixed;
      r_col_cnt <= r_col_cnt + COL_STEP;
    end
  end

  assign out_state = r_state;

endmodule

// File: tb/tb_aes_shift_mix.sv
// Directed + randomized bench for aes_shift_mix with 1/2/4 columns per cycle,
// checked against an array-based GF(2^8) reference model.
module tb_aes_shift_mix;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid_a  [3];
  logic         in_final_a  [3];
  logic         out_ready_a [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic [127:0] in_state_a  [3];
  logic [127:0] out_state_a [3];

  int n_err = 0;
  int n_chk = 0;

  aes_shift_mix #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_state(in_state_a[0]), .in_final(in_final_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .out_state(out_state_a[0])
  );

  aes_shift_mix #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_state(in_state_a[1]), .in_final(in_final_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .out_state(out_state_a[1])
  );

  aes_shift_mix #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_state(in_state_a[2]), .in_final(in_final_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .out_state(out_state_a[2])
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic fin);
    logic [7:0] m  [4][4];
    logic [7:0] sr [4][4];
    logic [7:0] o  [4][4];
    logic [7:0] base [4];
    logic [127:0] res;
    base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = s[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r][c] = m[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (fin) o[r][c] = sr[r][c];
        else begin
          o[r][c] = 8'h00;
          for (int k = 0; k < 4; k++)
            o[r][c] = o[r][c] ^ gmul(base[(k - r + 4) % 4], sr[k][c]);
        end
      end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = o[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input int idx, input logic [127:0] st, input logic fin,
                           input logic [127:0] exp_st, input int exp_lat, input string tag);
    int lat;
    chk({tag, "_ready_before"}, 128'(in_ready_a[idx]), 128'd1);
    in_valid_a[idx]  = 1'b1;
    in_state_a[idx]  = st;
    in_final_a[idx]  = fin;
    out_ready_a[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[idx] = 1'b0;
    lat = 1;
    while (!out_valid_a[idx] && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_state"}, out_state_a[idx], exp_st);
    @(posedge clk); #1;
    chk({tag, "_valid_after"}, 128'(out_valid_a[idx]), 128'd0);
    chk({tag, "_ready_after"}, 128'(in_ready_a[idx]), 128'd1);
  endtask

  task automatic run_stream(input int idx);
    logic [127:0] q[$];
    logic [127:0] exp_st;
    int sent, rcvd, cyc;
    logic drop;
    sent = 0; rcvd = 0; cyc = 0; drop = 1'b0;
    while (rcvd < 8 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (drop) begin
        in_valid_a[idx] = 1'b0;
        drop = 1'b0;
      end
      if (!in_valid_a[idx] && sent < 8) begin
        in_valid_a[idx] = 1'b1;
        in_state_a[idx] = rand128();
        in_final_a[idx] = 1'($urandom_range(0, 1));
      end
      out_ready_a[idx] = 1'($urandom_range(0, 1));
      if (out_valid_a[idx] && out_ready_a[idx]) begin
        if (q.size() == 0) begin
          chk($sformatf("stream%0d_unexpected_out", idx), out_state_a[idx], 128'hx);
        end else begin
          exp_st = q.pop_front();
          chk($sformatf("stream%0d_blk%0d", idx, rcvd), out_state_a[idx], exp_st);
        end
        rcvd++;
      end
      if (in_valid_a[idx] && in_ready_a[idx]) begin
        q.push_back(ref_model(in_state_a[idx], in_final_a[idx]));
        sent++;
        drop = 1'b1;
      end
    end
    in_valid_a[idx] = 1'b0;
    out_ready_a[idx] = 1'b1;
    chk($sformatf("stream%0d_count", idx), 128'(rcvd), 128'd8);
    chk($sformatf("stream%0d_leftover", idx), 128'(q.size()), 128'd0);
  endtask

  initial begin : main
    logic [127:0] st, held;
    int bad, waitc;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i] = 1'b0; in_final_a[i] = 1'b0;
      out_ready_a[i] = 1'b1; in_state_a[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d_out_valid", i), 128'(out_valid_a[i]), 128'd0);
      chk($sformatf("reset%0d_out_state", i), out_state_a[i], 128'd0);
      chk($sformatf("reset%0d_in_ready", i), 128'(in_ready_a[i]), 128'd1);
    end

    run_block(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
              128'h046681e5e0cb199a48f8d37a2806264c, 5, "fips_c1");
    run_block(1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
              128'h046681e5e0cb199a48f8d37a2806264c, 3, "fips_c2");
    run_block(2, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
              128'h046681e5e0cb199a48f8d37a2806264c, 2, "fips_c4");

    run_block(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
              128'h00050a0f04090e03080d02070c01060b, 1, "final_c1");
    run_block(2, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
              128'h00050a0f04090e03080d02070c01060b, 1, "final_c4");

    run_block(0, 128'hdb010101011301010101530101010145, 1'b0,
              128'h8e4da1bc010101010101010101010101, 5, "colchk_c1");
    run_block(1, 128'hdb010101011301010101530101010145, 1'b0,
              128'h8e4da1bc010101010101010101010101, 3, "colchk_c2");

    // Backpressure on the 1-column instance.
    st = rand128();
    in_valid_a[0] = 1'b1; in_state_a[0] = st; in_final_a[0] = 1'b0; out_ready_a[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    waitc = 0;
    while (!out_valid_a[0] && waitc < 16) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("bp_reach_done", 128'(out_valid_a[0]), 128'd1);
    chk("bp_state", out_state_a[0], ref_model(st, 1'b0));
    held = out_state_a[0];
    in_valid_a[0] = 1'b1; in_state_a[0] = rand128(); in_final_a[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_state_a[0] !== held || in_ready_a[0] !== 1'b0 || out_valid_a[0] !== 1'b1) bad++;
    end
    chk("bp_hold_cycles_bad", 128'(bad), 128'd0);
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid_a[0]), 128'd0);
    chk("bp_release_ready", 128'(in_ready_a[0]), 128'd1);
    chk("bp_idle_holds_state", out_state_a[0], held);

    // Reset during the second MIX cycle.
    in_valid_a[0] = 1'b1; in_state_a[0] = rand128(); in_final_a[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmix_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("rstmix_out_state", out_state_a[0], 128'd0);
    chk("rstmix_in_ready", 128'(in_ready_a[0]), 128'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_a[0] !== 1'b0) bad++;
    end
    chk("rstmix_no_stale_out", 128'(bad), 128'd0);
    st = rand128();
    run_block(0, st, 1'b0, ref_model(st, 1'b0), 5, "rstmix_next");

    for (int i = 0; i < 3; i++) begin
      st = rand128();
      run_block(i, st, 1'b0, ref_model(st, 1'b0), (i == 0) ? 5 : ((i == 1) ? 3 : 2),
                $sformatf("rand_norm%0d", i));
    end

    run_stream(0);
    run_stream(1);
    run_stream(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
